operand_fetch: RTL

- Register-read pipeline stage sitting between decode and execute; drives the read and write ports of the synchronous-read register file and owns its one-cycle read latency.
- Accepts decoded instructions over a valid/ready handshake and presents rs1/rs2 operand values to execute one cycle later.
- Bypasses writeback data that the register file would otherwise miss, since a register-file read returns the pre-write value when it coincides with a write to the same address.

---
 rtl/operand_fetch.sv | 88 ++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with writeback bypass; define OPERAND_FETCH_COMB_FWD_EN for same-cycle bypass onto held operands
module operand_fetch #(
  parameter int WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PAYLOAD_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_rs1,
  input  logic [ADDR_WIDTH-1:0]    in_rs2,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  input  logic                     wb_we,
  input  logic [ADDR_WIDTH-1:0]    wb_addr,
  input  logic [WIDTH-1:0]         wb_data,
  output logic [ADDR_WIDTH-1:0]    rf_r_addr1,
  output logic [ADDR_WIDTH-1:0]    rf_r_addr2,
  input  logic [WIDTH-1:0]         rf_read1,
  input  logic [WIDTH-1:0]         rf_read2,
  output logic                     rf_we,
  output logic [ADDR_WIDTH-1:0]    rf_w_addr,
  output logic [WIDTH-1:0]         rf_w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_rs1_data,
  output logic [WIDTH-1:0]         out_rs2_data,
  output logic [PAYLOAD_WIDTH-1:0] out_payload
);
  logic [ADDR_WIDTH-1:0]    rs1_q, rs2_q;
  logic [PAYLOAD_WIDTH-1:0] payload_q;
  logic                     fwd_valid1, fwd_valid2;
  logic [WIDTH-1:0]         fwd_data1, fwd_data2;
  logic                     accept, comb1, comb2;
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign rf_r_addr1  = accept ? in_rs1 : rs1_q;
  assign rf_r_addr2  = accept ? in_rs2 : rs2_q;
  assign rf_we       = wb_we;
  assign rf_w_addr   = wb_addr;
  assign rf_w_data   = wb_data;
  assign out_payload = payload_q;
`ifdef OPERAND_FETCH_COMB_FWD_EN
  assign comb1 = out_valid && wb_we && wb_addr == rs1_q;
  assign comb2 = out_valid && wb_we && wb_addr == rs2_q;
`else
  assign comb1 = 1'b0;
  assign comb2 = 1'b0;
`endif
  // Held instruction: flush wins over accept, consume drops valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      payload_q <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      rs1_q     <= in_rs1;
      rs2_q     <= in_rs2;
      payload_q <= in_payload;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  // Capture writes that the register file read would miss this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid1 <= 1'b0;
      fwd_valid2 <= 1'b0;
      fwd_data1  <= '0;
      fwd_data2  <= '0;
    end else begin
      fwd_valid1 <= wb_we && wb_addr == rf_r_addr1 && wb_addr != '0;
      fwd_valid2 <= wb_we && wb_addr == rf_r_addr2 && wb_addr != '0;
      fwd_data1  <= wb_data;
      fwd_data2  <= wb_data;
    end
  end
  // Operand select: x0, then same-cycle write, then registered bypass, then file
  always_comb begin
    out_rs1_data = rs1_q == '0 ? '0 : comb1 ? wb_data : fwd_valid1 ? fwd_data1 : rf_read1;
    out_rs2_data = rs2_q == '0 ? '0 : comb2 ? wb_data : fwd_valid2 ? fwd_data2 : rf_read2;
  end
endmodule
